// File: rtl/stump_shift_pkg.sv
// Shared definitions for the Stump multi-bit shift sequencer:
// shift operation encodings, sequencer state enum and default widths.
package stump_shift_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_ASR  = 2'b01;
  localparam logic [1:0] SHIFT_ROR  = 2'b10;
  localparam logic [1:0] SHIFT_RRC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/stump_shift_seq_step.sv
// Single-bit Stump shift step (purely combinational).
// none: value passes, carry 0. ASR/ROR/RRC shift right by one;
// the bit shifted out becomes the carry.
module stump_shift_seq_step
  import stump_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_c_in,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_c_out
);

  // Select the fill bit for the vacated MSB according to the operation
  always_comb begin
    o_result = i_operand;
    o_c_out  = 1'b0;
    case (i_op)
      SHIFT_ASR: begin
        o_result = {i_operand[WIDTH-1], i_operand[WIDTH-1:1]};
        o_c_out  = i_operand[0];
      end
      SHIFT_ROR: begin
        o_result = {i_operand[0], i_operand[WIDTH-1:1]};
        o_c_out  = i_operand[0];
      end
      SHIFT_RRC: begin
        o_result = {i_c_in, i_operand[WIDTH-1:1]};
        o_c_out  = i_operand[0];
      end
      default: begin
        o_result = i_operand;
        o_c_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/stump_shift_seq.sv
// Stump multi-bit shift sequencer: iterates the single-bit shift step
// once per clock (twice per clock when STUMP_SHIFT_SEQ_DUAL_EN is defined),
// threading the carry between steps.
//
// Handshake: start is accepted only in IDLE, where operand/c_in/shift_op/count
// are sampled. busy is high from the cycle after acceptance through the done
// cycle inclusive. done pulses for one cycle and result/c_out are valid in
// that cycle, then held until the next accepted start. start while busy is
// ignored.
//
// Optional feature macro: STUMP_SHIFT_SEQ_DUAL_EN.
module stump_shift_seq
  import stump_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic             c_in,
  input  logic [1:0]       shift_op,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_result;
  logic             r_c_out;

  logic             w_direct;
  logic             w_last;
  logic [WIDTH-1:0] w_s1_res;
  logic             w_s1_c;
  logic [WIDTH-1:0] w_step_res;
  logic             w_step_c;
  logic [CNT_W-1:0] w_step_dec;

  // A none-op or zero count needs no shifting and finishes straight away
  assign w_direct = (shift_op == SHIFT_NONE) || (count == '0);

  stump_shift_seq_step #(.WIDTH(WIDTH)) u_step1 (
    .i_operand (r_acc),
    .i_c_in    (r_carry),
    .i_op      (r_op),
    .o_result  (w_s1_res),
    .o_c_out   (w_s1_c)
  );

`ifdef STUMP_SHIFT_SEQ_DUAL_EN
  logic [WIDTH-1:0] w_s2_res;
  logic             w_s2_c;
  logic             w_use_two;

  stump_shift_seq_step #(.WIDTH(WIDTH)) u_step2 (
    .i_operand (w_s1_res),
    .i_c_in    (w_s1_c),
    .i_op      (r_op),
    .o_result  (w_s2_res),
    .o_c_out   (w_s2_c)
  );

  // Two steps per cycle unless only one step remains (odd final step)
  always_comb begin
    w_use_two  = (r_rem != CNT_W'(1));
    w_step_res = w_use_two ? w_s2_res : w_s1_res;
    w_step_c   = w_use_two ? w_s2_c   : w_s1_c;
    w_step_dec = w_use_two ? CNT_W'(2) : CNT_W'(1);
    w_last     = (r_rem <= CNT_W'(2));
  end
`else
  // One step per cycle
  always_comb begin
    w_step_res = w_s1_res;
    w_step_c   = w_s1_c;
    w_step_dec = CNT_W'(1);
    w_last     = (r_rem == CNT_W'(1));
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; SHIFT is entered only with rem >= 1 so rem never wraps
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = w_direct ? DONE : SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: latch on accepted start, shift in SHIFT, capture result on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_op     <= SHIFT_NONE;
      r_rem    <= '0;
      r_result <= '0;
      r_c_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= operand;
            r_carry <= c_in;
            r_op    <= shift_op;
            r_rem   <= count;
            if (w_direct) begin
              r_result <= operand;
              r_c_out  <= (shift_op == SHIFT_NONE) ? 1'b0 : c_in;
            end
          end
        end
        SHIFT: begin
          r_acc   <= w_step_res;
          r_carry <= w_step_c;
          r_rem   <= r_rem - w_step_dec;
          if (w_last) begin
            r_result <= w_step_res;
            r_c_out  <= w_step_c;
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign c_out     = r_c_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_stump_shift_seq.sv
// Directed testbench for stump_shift_seq: hand-computed vectors for ASR,
// ROR, RRC, zero count, none-op, max count, start-while-busy and mid-op reset.
module tb_stump_shift_seq;
  import stump_shift_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] operand;
  logic        c_in;
  logic [1:0]  shift_op;
  logic [3:0]  count;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;
  state_t      dbg_state;

  int n_cmp;
  int n_bad;

  stump_shift_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operand   (operand),
    .c_in      (c_in),
    .shift_op  (shift_op),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .c_out     (c_out),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected done latency in cycles after the accepting edge
  function automatic int lat_of(input logic [1:0] op, input int n);
    if (op == SHIFT_NONE || n == 0) return 1;
`ifdef STUMP_SHIFT_SEQ_DUAL_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Randomise don't-care inputs while no start is being presented
  task automatic scramble();
    operand  = 16'($urandom_range(0, 65535));
    c_in     = 1'($urandom_range(0, 1));
    shift_op = 2'($urandom_range(0, 3));
    count    = 4'($urandom_range(0, 15));
  endtask

  // Driver: present one start in the current cycle (called #1 after an edge
  // with the DUT idle), wait for done, check latency/busy/result/c_out,
  // and return one cycle after done so the next call is back-to-back.
  // poke_cyc: a cycle in which a spurious start is driven while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] opnd,
                        input logic ci, input int n, input logic [15:0] exp_res,
                        input logic exp_c, input int poke_cyc);
    int  lat;
    bit  got;
    bit  busy_ok;
    start    = 1'b1;
    operand  = opnd;
    c_in     = ci;
    shift_op = op;
    count    = 4'(n);
    lat      = 0;
    got      = 0;
    busy_ok  = 1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk);
      #1;
      scramble();
      start = (c == poke_cyc);
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) begin
        got = 1;
        lat = c;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_of(op, n)));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    chk({tag, "_cout"}, 32'(c_out), 32'(exp_c));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ASR 8004 by 2: C002/c0 then E001/c0
    run_op("asr2", SHIFT_ASR, 16'h8004, 1'b0, 2, 16'hE001, 1'b0, 0);
    // ROR by 1 then back-to-back ROR by 4 (carry in ignored by ROR)
    run_op("ror1", SHIFT_ROR, 16'h0001, 1'b0, 1, 16'h8000, 1'b1, 0);
    run_op("ror4", SHIFT_ROR, 16'h0001, 1'b1, 4, 16'h1000, 1'b0, 0);
    // RRC 0003 by 3: 0001/c1, 8000/c1, C000/c0
    run_op("rrc3", SHIFT_RRC, 16'h0003, 1'b0, 3, 16'hC000, 1'b0, 0);
    // RRC 0000 c_in=1 by 2: 8000/c0, 4000/c0
    run_op("rrc2", SHIFT_RRC, 16'h0000, 1'b1, 2, 16'h4000, 1'b0, 0);
    // ASR 7FFF by 1: 3FFF/c1
    run_op("asr1", SHIFT_ASR, 16'h7FFF, 1'b0, 1, 16'h3FFF, 1'b1, 0);
    // Zero count keeps operand and passes c_in
    run_op("ror0", SHIFT_ROR, 16'h1234, 1'b1, 0, 16'h1234, 1'b1, 0);
    // None-op: operand returned, carry forced 0
    run_op("none5", SHIFT_NONE, 16'hBEEF, 1'b1, 5, 16'hBEEF, 1'b0, 0);
    // Max count
    run_op("asr15", SHIFT_ASR, 16'h8000, 1'b0, 15, 16'hFFFF, 1'b0, 0);
    // Start pulsed during SHIFT (cycle 2) is ignored; ROR 00F0 by 8 -> F000/c1
    run_op("poke_shift", SHIFT_ROR, 16'h00F0, 1'b0, 8, 16'hF000, 1'b1, 2);
    // Start pulsed in the done cycle is ignored as well
    run_op("poke_done", SHIFT_RRC, 16'h0005, 1'b1, 1, 16'h8002, 1'b1, lat_of(SHIFT_RRC, 1));

    // Reset in cycle 2 of a count=8 operation
    start    = 1'b1;
    operand  = 16'h4000;
    c_in     = 1'b1;
    shift_op = SHIFT_ASR;
    count    = 4'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_res", 32'(result), 32'd0);
    chk("mid_rst_cout", 32'(c_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    run_op("after_rst", SHIFT_ASR, 16'h8004, 1'b0, 2, 16'hE001, 1'b0, 0);

    // Result held while idle with scrambled inputs
    repeat (3) begin
      @(posedge clk);
      #1;
      scramble();
    end
    chk("hold_res", 32'(result), 32'h0000E001);
    chk("hold_state", 32'(dbg_state), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
